mc_datapath: RTL and testbench

//  - Parametrised multi-cycle successor of the single-cycle datapath: register file with per-register flags, built-in ALU, and a req/ack memory port in place of same-cycle memory.
//  - Sits between the instruction sequencer (drives op_* with valid/ready) and the memory/VGA subsystem. Register 0 is the program counter.

---
 rtl/mc_datapath_if.sv | 36 +++
 rtl/mc_datapath.sv | 155 +++++++++++++++
 tb/tb_mc_datapath.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mc_datapath_if.sv
// Sequencer command channel and memory req/ack channel of mc_datapath.
// slave = datapath side, master = sequencer/memory side.
interface mc_datapath_if #(
   parameter int WIDTH = 16,
   parameter int RSEL  = 4
);
   logic             op_valid;
   logic             op_ready;
   logic [1:0]       op_kind;
   logic [2:0]       op_alu;
   logic [RSEL-1:0]  op_a_sel;
   logic [RSEL-1:0]  op_b_sel;
   logic [RSEL-1:0]  op_dst;
   logic             op_a_imm;
   logic             op_b_imm;
   logic [WIDTH-1:0] op_imm;

   logic             mem_req;
   logic             mem_we;
   logic [WIDTH-1:0] mem_addr;
   logic [WIDTH-1:0] mem_wdata;
   logic             mem_ack;
   logic [WIDTH-1:0] mem_rdata;

   modport slave (
      input  op_valid, op_kind, op_alu, op_a_sel, op_b_sel, op_dst,
             op_a_imm, op_b_imm, op_imm, mem_ack, mem_rdata,
      output op_ready, mem_req, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output op_valid, op_kind, op_alu, op_a_sel, op_b_sel, op_dst,
             op_a_imm, op_b_imm, op_imm, mem_ack, mem_rdata,
      input  op_ready, mem_req, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mc_datapath.sv
// Multi-cycle datapath: flagged register file (reg 0 = PC), 1-cycle ALU, req/ack memory port.
// Optional macro DATAPATH_MEM_TIMEOUT_EN aborts a memory op after TIMEOUT_CYCLES without ack.
module mc_datapath #(
   parameter int WIDTH          = 16,
   parameter int NREGS          = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   mc_datapath_if.slave           bus,
   output logic [NREGS*WIDTH-1:0] registers,
   output logic [NREGS-1:0]       overflow,
   output logic [NREGS-1:0]       errorbit,
   output logic [NREGS-1:0]       zeroflag,
   output logic [NREGS-1:0]       signflag
);
   localparam int RSEL = $clog2(NREGS);
   localparam int MSB  = WIDTH - 1;
   localparam logic [WIDTH-1:0] SHIFT_LIM = WIDTH'(WIDTH);

   typedef enum logic [1:0] {K_ALU = 2'b00, K_LOAD = 2'b01, K_STORE = 2'b10, K_FLAGS = 2'b11} kind_t;
   typedef enum logic [2:0] {A_ADD, A_SUB, A_AND, A_OR, A_XOR, A_SHL, A_SHR, A_PASSB} alu_t;
   typedef enum logic {S_IDLE, S_MEM} state_t;

   state_t           state, state_nx;
   logic [WIDTH-1:0] rf [NREGS];
   logic [RSEL-1:0]  pend_dst;
   logic [WIDTH-1:0] op_a, op_b, alu_res;
   logic             alu_ofl, alu_err;
   logic             alu_fire, mem_fire, mem_done, mem_abort, t_expired;
   kind_t            kind;

   assign kind = kind_t'(bus.op_kind);

   always_comb begin
      op_a    = bus.op_a_imm ? bus.op_imm : rf[bus.op_a_sel];
      op_b    = bus.op_b_imm ? bus.op_imm : rf[bus.op_b_sel];
      alu_res = '0;
      alu_ofl = 1'b0;
      alu_err = 1'b0;
      case (alu_t'(bus.op_alu))
         A_ADD: begin
            alu_res = op_a + op_b;
            alu_ofl = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
         end
         A_SUB: begin
            alu_res = op_a - op_b;
            alu_ofl = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
         end
         A_AND:   alu_res = op_a & op_b;
         A_OR:    alu_res = op_a | op_b;
         A_XOR:   alu_res = op_a ^ op_b;
         A_SHL: begin
            if (op_b >= SHIFT_LIM) alu_err = 1'b1;
            else                   alu_res = op_a << op_b;
         end
         A_SHR: begin
            if (op_b >= SHIFT_LIM) alu_err = 1'b1;
            else                   alu_res = op_a >> op_b;
         end
         default: alu_res = op_b;
      endcase
   end

`ifdef DATAPATH_MEM_TIMEOUT_EN
   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
   logic [TW-1:0] tcnt;

   // Held at zero outside MEM, so every MEM entry starts a fresh count.
   always_ff @(posedge clock) begin
      if (reset || state != S_MEM) tcnt <= '0;
      else if (!bus.mem_ack)       tcnt <= tcnt + 1'b1;
   end
   assign t_expired = (state == S_MEM) && (tcnt == T_LAST);
`else
   assign t_expired = 1'b0;
`endif

   always_ff @(posedge clock) begin
      if (reset) state <= S_IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      bus.op_ready = 1'b0;
      bus.mem_req  = 1'b0;
      alu_fire     = 1'b0;
      mem_fire     = 1'b0;
      mem_done     = 1'b0;
      mem_abort    = 1'b0;
      case (state)
         S_IDLE: begin
            bus.op_ready = 1'b1;
            if (bus.op_valid) begin
               if (kind == K_LOAD || kind == K_STORE) begin
                  mem_fire = 1'b1;
                  state_nx = S_MEM;
               end else begin
                  alu_fire = 1'b1;
               end
            end
         end
         default: begin
            bus.mem_req = 1'b1;
            if (bus.mem_ack) begin
               mem_done = 1'b1;
               state_nx = S_IDLE;
            end else if (t_expired) begin
               mem_abort = 1'b1;
               state_nx  = S_IDLE;
            end
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         for (int unsigned i = 0; i < NREGS; i++) rf[i] <= '0;
         overflow      <= '0;
         errorbit      <= '0;
         pend_dst      <= '0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
      end else begin
         // PC bump is issued first; any same-edge write to reg 0 comes later and wins.
         if (alu_fire || mem_done || mem_abort) rf[0] <= rf[0] + 1'b1;
         if (alu_fire) begin
            if (kind == K_ALU) rf[bus.op_dst] <= alu_res;
            overflow[bus.op_dst] <= alu_ofl;
            errorbit[bus.op_dst] <= alu_err;
         end
         if (mem_fire) begin
            bus.mem_we    <= (kind == K_STORE);
            bus.mem_addr  <= alu_res;
            bus.mem_wdata <= rf[bus.op_dst];
            pend_dst      <= bus.op_dst;
         end
         if (mem_done && !bus.mem_we) begin
            rf[pend_dst]       <= bus.mem_rdata;
            overflow[pend_dst] <= 1'b0;
            errorbit[pend_dst] <= 1'b0;
         end
         if (mem_abort) errorbit[pend_dst] <= 1'b1;
      end
   end

   for (genvar g = 0; g < NREGS; g++) begin : g_view
      assign registers[g*WIDTH +: WIDTH] = rf[g];
      assign zeroflag[g] = (rf[g] == '0);
      assign signflag[g] = rf[g][MSB];
   end
endmodule

// File: tb/tb_mc_datapath.sv
// Bench for mc_datapath: table-driven back-to-back ALU vectors with a scoreboard queue,
// plus hand sequences for memory latency, stale store data, reset abort and timeout.
module tb_mc_datapath;
   localparam int W = 16;
   localparam int N = 16;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic [N*W-1:0] registers;
   logic [N-1:0]   overflow, errorbit, zeroflag, signflag;

   mc_datapath_if #(.WIDTH(W), .RSEL(4)) bus ();

   mc_datapath #(.WIDTH(W), .NREGS(N), .TIMEOUT_CYCLES(4)) dut (
      .clock     (clock),
      .reset     (reset),
      .bus       (bus),
      .registers (registers),
      .overflow  (overflow),
      .errorbit  (errorbit),
      .zeroflag  (zeroflag),
      .signflag  (signflag)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] kind; logic [2:0] alu; logic [3:0] a_sel, b_sel, dst;
      logic a_imm, b_imm; logic [15:0] imm; logic [15:0] val; logic ofl, err;
   } vec_t;
   typedef struct { logic [3:0] dst; logic [15:0] val; logic ofl, err; logic [15:0] pc; } exp_t;

   vec_t  vt [17];
   exp_t  sb [$];
   int    n_cmp = 0;
   int    n_bad = 0;
   logic [15:0] exp_pc = '0;
   int    nreq, nbusy;

   function automatic vec_t mk(input logic [1:0] k, input logic [2:0] f, input int a, input int b,
                               input int d, input logic ai, input logic bi, input logic [15:0] imm,
                               input logic [15:0] val, input logic ofl, input logic err);
      vec_t v;
      v.kind = k; v.alu = f; v.a_sel = 4'(a); v.b_sel = 4'(b); v.dst = 4'(d);
      v.a_imm = ai; v.b_imm = bi; v.imm = imm; v.val = val; v.ofl = ofl; v.err = err;
      return v;
   endfunction

   function automatic logic [15:0] rv(input logic [3:0] i);
      return registers[i*W +: W];
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      bus.op_valid = 1'b1; bus.op_kind = v.kind; bus.op_alu = v.alu;
      bus.op_a_sel = v.a_sel; bus.op_b_sel = v.b_sel; bus.op_dst = v.dst;
      bus.op_a_imm = v.a_imm; bus.op_b_imm = v.b_imm; bus.op_imm = v.imm;
   endtask

   task automatic push(input logic [3:0] dst, input logic [15:0] val, input logic ofl,
                       input logic err, input logic writes_pc);
      exp_t e;
      exp_pc = writes_pc ? val : exp_pc + 16'd1;
      e.dst = dst; e.val = val; e.ofl = ofl; e.err = err; e.pc = exp_pc;
      sb.push_back(e);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      n_cmp++;
      if (sb.size() == 0) begin
         n_bad++;
         $display("FAIL %s.scoreboard: got empty queue, expected an entry", tag);
         return;
      end
      n_cmp--;
      e = sb.pop_front();
      chk($sformatf("%s.r%0d", tag, e.dst), rv(e.dst), e.val);
      chk($sformatf("%s.ovf%0d", tag, e.dst), overflow[e.dst], e.ofl);
      chk($sformatf("%s.err%0d", tag, e.dst), errorbit[e.dst], e.err);
      chk($sformatf("%s.zf%0d", tag, e.dst), zeroflag[e.dst], e.val == 16'd0);
      chk($sformatf("%s.sf%0d", tag, e.dst), signflag[e.dst], e.val[15]);
      chk($sformatf("%s.pc", tag), rv(4'd0), e.pc);
   endtask

   // Called at the first negedge of MEM; returns at the first negedge with mem_req low.
   task automatic mem_cycle(input int ack_at, input logic [15:0] rd, output int nr, output int nb);
      nr = 0; nb = 0;
      for (int c = 0; c < 40; c++) begin
         if (!bus.mem_req) break;
         nr++;
         if (!bus.op_ready) nb++;
         if (nr == ack_at) begin bus.mem_ack = 1'b1; bus.mem_rdata = rd; end
         @(negedge clock);
         bus.mem_ack = 1'b0;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish by 200000, expected completion");
      $fatal(1);
   end

   initial begin
      bus.op_valid = 1'b0; bus.op_kind = '0; bus.op_alu = '0; bus.op_a_sel = '0;
      bus.op_b_sel = '0; bus.op_dst = '0; bus.op_a_imm = 1'b0; bus.op_b_imm = 1'b0;
      bus.op_imm = '0; bus.mem_ack = 1'b0; bus.mem_rdata = '0;

      vt[0]  = mk(2'd0, 3'd7, 0, 0, 1, 0, 1, 16'h7FFF, 16'h7FFF, 0, 0);
      vt[1]  = mk(2'd0, 3'd0, 1, 0, 2, 0, 1, 16'h0001, 16'h8000, 1, 0);
      vt[2]  = mk(2'd0, 3'd5, 1, 0, 3, 0, 1, 16'd16,   16'h0000, 0, 1);
      vt[3]  = mk(2'd0, 3'd7, 0, 0, 4, 0, 1, 16'h0001, 16'h0001, 0, 0);
      vt[4]  = mk(2'd0, 3'd5, 4, 0, 6, 0, 1, 16'd4,    16'h0010, 0, 0);
      vt[5]  = mk(2'd0, 3'd1, 2, 0, 7, 0, 1, 16'h0001, 16'h7FFF, 1, 0);
      vt[6]  = mk(2'd0, 3'd2, 1, 2, 8, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vt[7]  = mk(2'd0, 3'd3, 1, 2, 9, 0, 0, 16'h0000, 16'hFFFF, 0, 0);
      vt[8]  = mk(2'd0, 3'd4, 9, 0, 10, 0, 1, 16'h00FF, 16'hFF00, 0, 0);
      vt[9]  = mk(2'd0, 3'd6, 9, 0, 11, 0, 1, 16'd15,   16'h0001, 0, 0);
      vt[10] = mk(2'd0, 3'd6, 9, 0, 12, 0, 1, 16'hFFFF, 16'h0000, 0, 1);
      vt[11] = mk(2'd3, 3'd0, 1, 1, 4, 0, 0, 16'h0000, 16'h0001, 1, 0);
      vt[12] = mk(2'd0, 3'd1, 10, 10, 10, 0, 0, 16'h0000, 16'h0000, 0, 0);
      vt[13] = mk(2'd0, 3'd0, 4, 4, 4, 0, 0, 16'h0000, 16'h0002, 0, 0);
      vt[14] = mk(2'd0, 3'd7, 0, 0, 0, 0, 1, 16'h0100, 16'h0100, 0, 0);
      vt[15] = mk(2'd0, 3'd0, 0, 0, 13, 0, 1, 16'h0001, 16'h0101, 0, 0);
      vt[16] = mk(2'd0, 3'd1, 0, 11, 14, 1, 0, 16'h0003, 16'h0002, 0, 0);

      repeat (2) @(negedge clock);
      reset = 1'b0;
      chk("rst.regs_zero", registers == '0, 1);
      chk("rst.overflow", overflow, 0);
      chk("rst.errorbit", errorbit, 0);
      chk("rst.mem_req", bus.mem_req, 0);
      chk("rst.mem_we", bus.mem_we, 0);
      chk("rst.mem_addr", bus.mem_addr, 0);
      chk("rst.mem_wdata", bus.mem_wdata, 0);
      chk("rst.op_ready", bus.op_ready, 1);

      // ALU vectors issued on consecutive cycles with no idle gap
      for (int i = 0; i < 17; i++) begin
         chk($sformatf("vec%0d.op_ready", i), bus.op_ready, 1);
         drive(vt[i]);
         push(vt[i].dst, vt[i].val, vt[i].ofl, vt[i].err, vt[i].kind == 2'd0 && vt[i].dst == 4'd0);
         @(negedge clock);
         pop_chk($sformatf("vec%0d", i));
      end
      bus.op_valid = 1'b0;

      // ack while idle must be ignored
      bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1234;
      @(negedge clock);
      bus.mem_ack = 1'b0;
      chk("idle_ack.r5", rv(4'd5), 16'h0000);
      chk("idle_ack.pc", rv(4'd0), exp_pc);

      // LOAD mem[0x0040] -> r5, ack on third request cycle
      drive(mk(2'd1, 3'd7, 0, 0, 5, 0, 1, 16'h0040, 16'h0, 0, 0));
      push(4'd5, 16'hBEEF, 0, 0, 0);
      @(negedge clock);
      bus.op_valid = 1'b0;
      chk("load.mem_we", bus.mem_we, 0);
      chk("load.mem_addr", bus.mem_addr, 16'h0040);
      mem_cycle(3, 16'hBEEF, nreq, nbusy);
      chk("load.req_cycles", nreq, 3);
      chk("load.busy_cycles", nbusy, 3);
      pop_chk("load");

      // STORE r5 -> mem[0x0080]; an ALU op overwriting r5 waits behind it
      drive(mk(2'd2, 3'd7, 0, 0, 5, 0, 1, 16'h0080, 16'h0, 0, 0));
      push(4'd5, 16'hBEEF, 0, 0, 0);
      @(negedge clock);
      chk("store.mem_we", bus.mem_we, 1);
      chk("store.mem_addr", bus.mem_addr, 16'h0080);
      chk("store.mem_wdata", bus.mem_wdata, 16'hBEEF);
      drive(mk(2'd0, 3'd7, 0, 0, 5, 0, 1, 16'h1111, 16'h1111, 0, 0));
      mem_cycle(2, 16'h0000, nreq, nbusy);
      chk("store.req_cycles", nreq, 2);
      pop_chk("store");
      push(4'd5, 16'h1111, 0, 0, 0);
      @(negedge clock);
      bus.op_valid = 1'b0;
      pop_chk("after_store");
      chk("after_store.mem_wdata", bus.mem_wdata, 16'hBEEF);

      // reset during a LOAD abandons it; a late ack changes nothing
      drive(mk(2'd1, 3'd7, 0, 0, 6, 0, 1, 16'h0040, 16'h0, 0, 0));
      @(negedge clock);
      bus.op_valid = 1'b0;
      chk("rstload.mem_req", bus.mem_req, 1);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      chk("rstload.req_dropped", bus.mem_req, 0);
      bus.mem_ack = 1'b1; bus.mem_rdata = 16'hDEAD;
      @(negedge clock);
      bus.mem_ack = 1'b0;
      chk("rstload.regs_zero", registers == '0, 1);
      chk("rstload.errorbit", errorbit, 0);
      chk("rstload.mem_req", bus.mem_req, 0);
      chk("rstload.op_ready", bus.op_ready, 1);
      exp_pc = '0;

      drive(mk(2'd1, 3'd7, 0, 0, 7, 0, 1, 16'h0040, 16'h0, 0, 0));
`ifdef DATAPATH_MEM_TIMEOUT_EN
      push(4'd7, 16'h0000, 0, 1, 0);
      @(negedge clock);
      bus.op_valid = 1'b0;
      mem_cycle(1000, 16'h0000, nreq, nbusy);
      chk("timeout.req_cycles", nreq, 4);
      chk("timeout.op_ready", bus.op_ready, 1);
      pop_chk("timeout");
`else
      push(4'd7, 16'h5A5A, 0, 0, 0);
      @(negedge clock);
      bus.op_valid = 1'b0;
      mem_cycle(30, 16'h5A5A, nreq, nbusy);
      chk("longwait.req_cycles", nreq, 30);
      pop_chk("longwait");
`endif

      // ack arriving on the 4th MEM cycle completes normally and clears errorbit
      drive(mk(2'd1, 3'd7, 0, 0, 7, 0, 1, 16'h0044, 16'h0, 0, 0));
      push(4'd7, 16'h0077, 0, 0, 0);
      @(negedge clock);
      bus.op_valid = 1'b0;
      mem_cycle(4, 16'h0077, nreq, nbusy);
      chk("ack4.req_cycles", nreq, 4);
      pop_chk("ack4");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
